// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU / host loader requesters, the arbiter and the
// single-port data memory. The arbiter sits on the slave modport.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              c_valid;
  logic              c_ready;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic [BE_W-1:0]   c_be;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;

  logic              h_valid;
  logic              h_ready;
  logic              h_we;
  logic [ADDR_W-1:0] h_addr;
  logic [DATA_W-1:0] h_wdata;
  logic [BE_W-1:0]   h_be;
  logic              h_rvalid;
  logic [DATA_W-1:0] h_rdata;

  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [BE_W-1:0]   m_be;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  c_valid, c_we, c_addr, c_wdata, c_be,
    output c_ready, c_rvalid, c_rdata,
    input  h_valid, h_we, h_addr, h_wdata, h_be,
    output h_ready, h_rvalid, h_rdata,
    output m_en, m_we, m_addr, m_wdata, m_be,
    input  m_rdata
  );

  modport master (
    output c_valid, c_we, c_addr, c_wdata, c_be,
    input  c_ready, c_rvalid, c_rdata,
    output h_valid, h_we, h_addr, h_wdata, h_be,
    input  h_ready, h_rvalid, h_rdata,
    input  m_en, m_we, m_addr, m_wdata, m_be,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// Grants are combinational; read data returns one cycle later to its owner.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus,
  output logic           last_grant
);
  localparam int BE_W = DATA_W / 8;

  logic        c_gnt;
  logic        h_gnt;
  logic        pending_valid;
  logic        pending_id;
  logic [15:0] c_grants;
  logic [15:0] h_grants;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    c_gnt = 1'b0;
    h_gnt = 1'b0;
    if (rst_n) begin
      if (bus.c_valid && (!bus.h_valid || last_grant)) begin
        c_gnt = 1'b1;
      end else if (bus.h_valid) begin
        h_gnt = 1'b1;
      end
    end
  end

  assign bus.c_ready = c_gnt;
  assign bus.h_ready = h_gnt;

  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_be    = '0;
    if (c_gnt) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.c_we;
      bus.m_addr  = bus.c_addr;
      bus.m_wdata = bus.c_wdata;
      bus.m_be    = bus.c_be;
    end else if (h_gnt) begin
      bus.m_en    = 1'b1;
      bus.m_we    = bus.h_we;
      bus.m_addr  = bus.h_addr;
      bus.m_wdata = bus.h_wdata;
      bus.m_be    = bus.h_be;
    end
  end

  // The memory has a fixed one-cycle read latency, so a single owner tag suffices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= 1'b1;
      pending_valid <= 1'b0;
      pending_id    <= 1'b0;
      c_grants      <= 16'h0000;
      h_grants      <= 16'h0000;
    end else begin
      pending_valid <= (c_gnt && !bus.c_we) || (h_gnt && !bus.h_we);
      if (c_gnt || h_gnt) begin
        last_grant <= h_gnt;
        pending_id <= h_gnt;
      end
      if (c_gnt && (c_grants != 16'hFFFF)) begin
        c_grants <= c_grants + 16'h0001;
      end
      if (h_gnt && (h_grants != 16'hFFFF)) begin
        h_grants <= h_grants + 16'h0001;
      end
    end
  end

  assign bus.c_rvalid = rst_n && pending_valid && !pending_id;
  assign bus.h_rvalid = rst_n && pending_valid && pending_id;
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
  assign bus.h_rdata  = bus.h_rvalid ? bus.m_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Random and directed stimulus for dmem_arbiter, checked cycle by cycle
// against a transaction-level model of round-robin grants and read returns.
module tb_dmem_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } req_t;

  typedef struct {
    bit          owner;
    logic [31:0] data;
    int          due;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic last_grant;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .last_grant (last_grant)
  );

  always #5 clk = ~clk;

  int    tests = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    exp_last = 1'b1;
  int    exp_cg = 0;
  int    exp_hg = 0;
  resp_t rq[$];
  req_t  creq;
  req_t  hreq;
  bit    c_won;
  bit    h_won;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h1F : ((a ^ 32'hA5A5_0000) + 32'h0000_1234);
  endfunction

  // Memory stand-in: one-cycle read latency, junk on the bus otherwise.
  always @(posedge clk) begin
    if (bus.m_en && !bus.m_we) bus.m_rdata <= mem_fn(bus.m_addr);
    else                       bus.m_rdata <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input req_t c, input req_t h);
    creq = c;
    hreq = h;
    bus.c_valid = c.valid; bus.c_we = c.we; bus.c_addr = c.addr;
    bus.c_wdata = c.wdata; bus.c_be = c.be;
    bus.h_valid = h.valid; bus.h_we = h.we; bus.h_addr = h.addr;
    bus.h_wdata = h.wdata; bus.h_be = h.be;
  endtask

  function automatic req_t mk(input bit v, input bit we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] be);
    req_t r;
    r.valid = v; r.we = we; r.addr = a; r.wdata = d; r.be = be;
    return r;
  endfunction

  // Check one cycle at the falling edge, then advance the model at the rising edge.
  task automatic runCycle(output bit cg, output bit hg);
    bit          ev_c, ev_h;
    logic [31:0] ed;
    req_t        w;
    @(negedge clk);
    cg = 1'b0; hg = 1'b0;
    if (creq.valid && hreq.valid) begin
      if (exp_last) cg = 1'b1; else hg = 1'b1;
    end else begin
      cg = creq.valid;
      hg = hreq.valid;
    end
    ev_c = 1'b0; ev_h = 1'b0; ed = '0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      ed = rq[0].data;
      if (rq[0].owner) ev_h = 1'b1; else ev_c = 1'b1;
    end
    w = cg ? creq : hreq;
    checkOutput("c_ready", bus.c_ready, cg);
    checkOutput("h_ready", bus.h_ready, hg);
    checkOutput("m_en", bus.m_en, cg | hg);
    checkOutput("m_we", bus.m_we, (cg | hg) ? w.we : 1'b0);
    checkOutput("m_be", bus.m_be, (cg | hg) ? w.be : 4'h0);
    if (cg | hg) begin
      checkOutput("m_addr", bus.m_addr, w.addr);
      checkOutput("m_wdata", bus.m_wdata, w.wdata);
    end
    checkOutput("c_rvalid", bus.c_rvalid, ev_c);
    checkOutput("h_rvalid", bus.h_rvalid, ev_h);
    checkOutput("c_rdata", bus.c_rdata, ev_c ? ed : 32'h0);
    checkOutput("h_rdata", bus.h_rdata, ev_h ? ed : 32'h0);
    checkOutput("last_grant", last_grant, exp_last);
    @(posedge clk);
    if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
    if (cg | hg) begin
      exp_last = hg;
      if (cg && exp_cg < 65535) exp_cg++;
      if (hg && exp_hg < 65535) exp_hg++;
      if (!w.we) rq.push_back('{owner: hg, data: mem_fn(w.addr), due: cyc + 1});
    end
    cyc++;
    #1;
  endtask

  task automatic modelReset();
    exp_last = 1'b1;
    exp_cg = 0;
    exp_hg = 0;
    rq.delete();
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    applyStimulus(mk(0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0));
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_c_grants"}, dut.c_grants, exp_cg);
    checkOutput({tag, "_h_grants"}, dut.h_grants, exp_hg);
  endtask

  initial begin
    req_t idle;
    int   c_wait, h_wait;
    idle = mk(0, 0, 0, 0, 0);
    applyStimulus(mk(1, 0, 32'h40, 0, 4'hF), mk(1, 1, 32'h44, 32'h1, 4'hF));

    // Held in reset with both requesting: nothing may be granted.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_c_ready", bus.c_ready, 1'b0);
    checkOutput("rst_h_ready", bus.h_ready, 1'b0);
    checkOutput("rst_m_en", bus.m_en, 1'b0);
    checkOutput("rst_m_be", bus.m_be, 4'h0);
    checkOutput("rst_c_rvalid", bus.c_rvalid, 1'b0);
    checkOutput("rst_h_rdata", bus.h_rdata, 32'h0);
    checkOutput("rst_last_grant", last_grant, 1'b1);
    checkCounters("rst");
    applyStimulus(idle, idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // CPU-only read of 0x10, returns 0x1F.
    applyStimulus(mk(1, 0, 32'h10, 32'h0, 4'hF), idle);
    runCycle(c_won, h_won);
    applyStimulus(idle, idle);
    runCycle(c_won, h_won);

    // Contention straight after reset: CPU first, then host write.
    pulseReset();
    applyStimulus(mk(1, 0, 32'h4, 0, 4'hF), mk(1, 1, 32'h8, 32'hDEADBEEF, 4'hF));
    runCycle(c_won, h_won);
    applyStimulus(idle, hreq);
    runCycle(c_won, h_won);
    applyStimulus(idle, idle);
    runCycle(c_won, h_won);

    // Six cycles of continuous contention alternate evenly.
    pulseReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(1, 0, 32'(i * 8), 0, 4'hF), mk(1, 1, 32'(i * 8 + 4), 32'(i), 4'h5));
      runCycle(c_won, h_won);
    end
    checkOutput("alt_c_grants", dut.c_grants, 32'd3);
    checkOutput("alt_h_grants", dut.h_grants, 32'd3);

    // Host read then CPU read, responses in grant order.
    applyStimulus(idle, mk(1, 0, 32'h20, 0, 4'hF));
    runCycle(c_won, h_won);
    applyStimulus(mk(1, 0, 32'h24, 0, 4'hF), idle);
    runCycle(c_won, h_won);
    applyStimulus(idle, idle);
    runCycle(c_won, h_won);

    // Partial host write: single memory cycle, no response.
    applyStimulus(idle, mk(1, 1, 32'h30, 32'h1234_5678, 4'h3));
    runCycle(c_won, h_won);
    applyStimulus(idle, idle);
    runCycle(c_won, h_won);
    runCycle(c_won, h_won);

    // Reset lands while a CPU read is in flight; its response must vanish.
    applyStimulus(mk(1, 0, 32'h50, 0, 4'hF), idle);
    runCycle(c_won, h_won);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_c_rvalid", bus.c_rvalid, 1'b0);
    checkOutput("midrst_c_rdata", bus.c_rdata, 32'h0);
    checkOutput("midrst_c_ready", bus.c_ready, 1'b0);
    checkOutput("midrst_m_en", bus.m_en, 1'b0);
    checkOutput("midrst_last_grant", last_grant, 1'b1);
    checkCounters("midrst");
    applyStimulus(idle, idle);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    runCycle(c_won, h_won);
    runCycle(c_won, h_won);

    // Randomized traffic; requests hold until granted.
    c_wait = 0;
    h_wait = 0;
    for (int i = 0; i < 400; i++) begin
      req_t c, h;
      c = creq;
      h = hreq;
      if (!c.valid && $urandom_range(0, 1) == 1)
        c = mk(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, $urandom, 4'($urandom));
      if (!h.valid && $urandom_range(0, 2) != 0)
        h = mk(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 1023)) << 2, $urandom, 4'($urandom));
      applyStimulus(c, h);
      runCycle(c_won, h_won);
      if (c_won) begin
        checkOutput("c_wait_bound", 32'(c_wait <= 1), 32'd1);
        c_wait = 0;
        c.valid = 1'b0;
      end else if (c.valid) c_wait++;
      if (h_won) begin
        checkOutput("h_wait_bound", 32'(h_wait <= 1), 32'd1);
        h_wait = 0;
        h.valid = 1'b0;
      end else if (h.valid) h_wait++;
      applyStimulus(c, h);
    end
    applyStimulus(idle, idle);
    runCycle(c_won, h_won);
    checkCounters("final");

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of all address ports.
REQ-002 SHALL have parameter DATA_W, default 32, data width; byte-enable width is DATA_W/8.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  reset, asynchronous and active-low.
REQ-005 c_valid / h_valid  input  1  request valid, from the CPU (requester 0) and from the host loader (requester 1).
REQ-006 c_ready / h_ready  output  1  request accepted this cycle; the CPU treats low as a stall.
REQ-007 c_we / h_we  input  1  1 = write, 0 = read.
REQ-008 c_addr / h_addr  input  ADDR_W  request byte address.
REQ-009 c_wdata / h_wdata  input  DATA_W  write data.
REQ-010 c_be / h_be  input  DATA_W/8  write byte enables.
REQ-011 c_rvalid / h_rvalid  output  1  read data valid for that requester.
REQ-012 c_rdata / h_rdata  output  DATA_W  read data.
REQ-013 m_en, m_we  output  1  memory enable and write enable to the single-port data memory.
REQ-014 m_addr  output  ADDR_W; m_wdata  output  DATA_W; m_be  output  DATA_W/8.
REQ-015 m_rdata  input  DATA_W  memory read data, valid exactly one cycle after a read with m_en=1.
REQ-016 last_grant  output  1  requester granted most recently (0 = CPU, 1 = host).

Function
REQ-017 SHALL accept at most one request per cycle: grant = (x_valid & x_ready).
REQ-018 Only one valid -> that requester SHALL be granted in the same cycle (combinational ready).
REQ-019 Both valid -> the requester that is not last_grant SHALL be granted (round-robin); the other requester's ready SHALL be 0.
REQ-020 last_grant SHALL update to the granted requester at the clock edge of each grant and hold otherwise.
REQ-021 Granted cycle: m_en=1, m_we/m_addr/m_wdata/m_be SHALL equal the winner's inputs combinationally; no grant -> m_en=0, m_we=0, m_be=0.
REQ-022 Write SHALL complete in its grant cycle; no response is generated.
REQ-023 Read granted in cycle N SHALL assert the owner's x_rvalid for exactly cycle N+1, with x_rdata=m_rdata; the other requester's rvalid SHALL stay 0.
REQ-024 Owner tag for the read in flight SHALL be held in a 1-entry register (pending_valid, pending_id).
REQ-025 Back-to-back reads SHALL be accepted every cycle (fully pipelined); response order SHALL equal grant order.
REQ-026 x_rdata SHALL be 0 whenever x_rvalid=0.
REQ-027 A requester holding valid SHALL keep its request fields stable until ready; the arbiter SHALL NOT drop a pending request, and round-robin bounds any wait to 1 cycle.
REQ-028 Saturating 16-bit counters c_grants and h_grants SHALL count grants, stick at 0xFFFF and be readable hierarchically for verification.

Reset
REQ-029 Reset low SHALL asynchronously force last_grant=1 (so the CPU wins the first contention), pending_valid=0, pending_id=0, and both counters to 0.
REQ-030 While Reset is low: all ready=0, m_en=0, m_we=0, m_be=0, both rvalid=0, both rdata=0.
REQ-031 Reset asserted while a read is in flight SHALL cancel its response; no rvalid follows reset release.
REQ-032 First grant is possible in the first cycle after Reset deasserts.

Verification
REQ-033 CPU-only read addr 0x10, m_rdata=0x0000001F next cycle -> c_ready=1 in cycle N, c_rvalid=1 and c_rdata=0x1F in N+1, h_rvalid=0.
REQ-034 Both valid after reset, CPU read 0x4 / host write 0x8 data 0xDEADBEEF be=0xF -> CPU granted in N, host granted in N+1 with m_we=1 and m_wdata=0xDEADBEEF; last_grant 0 then 1.
REQ-035 Both valid continuously for 6 cycles -> grants alternate C,H,C,H,C,H; c_grants=h_grants=3.
REQ-036 Host read at N, CPU read at N+1 (addresses 0x20, 0x24) -> h_rvalid at N+1, c_rvalid at N+2, each rdata matching its own address's m_rdata.
REQ-037 Reset pulled low mid-cycle after a CPU read grant -> outputs go to reset values immediately; no c_rvalid after release; counters=0.
REQ-038 Host write with be=0x3 -> m_be=0x3, m_en=1 for exactly one cycle, no rvalid on either side.
